// File: rtl/mem_port_arbiter_pkg.sv
// mips_mem_pkg: shared types and constants for the main-memory port arbiter
package mips_mem_pkg;
   localparam int WORD_W = 32;
   localparam logic REQ_DATA = 1'b0;
   localparam logic REQ_FETCH = 1'b1;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared memory port
interface mem_port_arbiter_if;
   import mips_mem_pkg::*;
   logic              d_req;
   logic              d_we;
   logic              d_is_byte;
   logic [WORD_W-1:0] d_addr;
   logic [WORD_W-1:0] d_wdata;
   logic [WORD_W-1:0] d_rdata;
   logic              d_ready;
   logic              i_req;
   logic [WORD_W-1:0] i_addr;
   logic [WORD_W-1:0] i_rdata;
   logic              i_ready;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_write_en;
   logic              mem_is_byte;
   logic [WORD_W-1:0] mem_rdata;
   logic              busy;
   modport slave (
      input  d_req, d_we, d_is_byte, d_addr, d_wdata, i_req, i_addr, mem_rdata,
      output d_rdata, d_ready, i_rdata, i_ready, mem_addr, mem_wdata, mem_write_en, mem_is_byte, busy
   );
   modport master (
      output d_req, d_we, d_is_byte, d_addr, d_wdata, i_req, i_addr, mem_rdata,
      input  d_rdata, d_ready, i_rdata, i_ready, mem_addr, mem_wdata, mem_write_en, mem_is_byte, busy
   );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; a tie goes to the requester not granted last
module rr_pick2
   import mips_mem_pkg::*;
(
   input  logic req_d,
   input  logic req_i,
   input  logic last_grant,
   output logic gnt_vld,
   output logic gnt_id
);
   assign gnt_vld = req_d | req_i;
   assign gnt_id  = (req_d && req_i) ? ((last_grant == REQ_FETCH) ? REQ_DATA : REQ_FETCH)
                                     : (req_i ? REQ_FETCH : REQ_DATA);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between data and fetch requesters
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int MEM_LATENCY = 4
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.slave  bus
);
   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              who_q, who_d, last_q, last_d, we_q, we_d, byte_q, byte_d;
   logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [WORD_W-1:0] d_rdata_q, d_rdata_d, i_rdata_q, i_rdata_d;
   logic              gnt_vld, gnt_id, access;
   rr_pick2 u_pick (
      .req_d      (bus.d_req),
      .req_i      (bus.i_req),
      .last_grant (last_q),
      .gnt_vld    (gnt_vld),
      .gnt_id     (gnt_id)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         who_q     <= REQ_DATA;
         last_q    <= REQ_FETCH;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         d_rdata_q <= '0;
         i_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         who_q     <= who_d;
         last_q    <= last_d;
         we_q      <= we_d;
         byte_q    <= byte_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         d_rdata_q <= d_rdata_d;
         i_rdata_q <= i_rdata_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      who_d     = who_q;
      last_d    = last_q;
      we_d      = we_q;
      byte_d    = byte_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      d_rdata_d = d_rdata_q;
      i_rdata_d = i_rdata_q;
      case (state_q)
         IDLE: if (gnt_vld) begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
            who_d   = gnt_id;
            last_d  = gnt_id;
            addr_d  = (gnt_id == REQ_FETCH) ? bus.i_addr : bus.d_addr;
            wdata_d = (gnt_id == REQ_FETCH) ? '0 : bus.d_wdata;
            we_d    = (gnt_id == REQ_DATA) && bus.d_we;
            byte_d  = (gnt_id == REQ_DATA) && bus.d_is_byte;
         end
         ACCESS: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == '0) begin
               state_d   = DONE;
               cnt_d     = '0;
               d_rdata_d = (!we_q && who_q == REQ_DATA) ? bus.mem_rdata : d_rdata_q;
               i_rdata_d = (!we_q && who_q == REQ_FETCH) ? bus.mem_rdata : i_rdata_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign access           = (state_q == ACCESS);
   assign bus.mem_addr     = access ? addr_q : '0;
   assign bus.mem_wdata    = access ? wdata_q : '0;
   assign bus.mem_is_byte  = access && byte_q;
   // the counter still holds its load value only in the first ACCESS cycle
   assign bus.mem_write_en = access && we_q && (cnt_q == CNT_INIT);
   assign bus.d_ready      = (state_q == DONE) && (who_q == REQ_DATA);
   assign bus.i_ready      = (state_q == DONE) && (who_q == REQ_FETCH);
   assign bus.busy         = (state_q != IDLE);
   assign bus.d_rdata      = d_rdata_q;
   assign bus.i_rdata      = i_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters on two arbiters (latency 4 and 1) checked against a cycle-arithmetic model
module tb_mem_port_arbiter;
   import mips_mem_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        d_req[2], d_we[2], d_is_byte[2], i_req[2];
   logic [31:0] d_addr[2], d_wdata[2], i_addr[2], mem_rdata[2];
   logic [31:0] d_rdata[2], i_rdata[2], mem_addr[2], mem_wdata[2];
   logic        d_ready[2], i_ready[2], mem_write_en[2], mem_is_byte[2], busy[2];
   int          checks = 0, errors = 0, e = 0;
   int          g_e[2], free_e[2];
   logic        who[2], last[2], m_we[2], m_byte[2];
   logic [31:0] m_addr[2], m_wdata[2], exp_d[2], exp_i[2];
   always #5 clk = ~clk;
   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : u
         mem_port_arbiter_if bus ();
         assign bus.d_req     = d_req[g];
         assign bus.d_we      = d_we[g];
         assign bus.d_is_byte = d_is_byte[g];
         assign bus.d_addr    = d_addr[g];
         assign bus.d_wdata   = d_wdata[g];
         assign bus.i_req     = i_req[g];
         assign bus.i_addr    = i_addr[g];
         assign bus.mem_rdata = mem_rdata[g];
         assign d_rdata[g]      = bus.d_rdata;
         assign i_rdata[g]      = bus.i_rdata;
         assign d_ready[g]      = bus.d_ready;
         assign i_ready[g]      = bus.i_ready;
         assign mem_addr[g]     = bus.mem_addr;
         assign mem_wdata[g]    = bus.mem_wdata;
         assign mem_write_en[g] = bus.mem_write_en;
         assign mem_is_byte[g]  = bus.mem_is_byte;
         assign busy[g]         = bus.busy;
         mem_port_arbiter #(.MEM_LATENCY(g == 0 ? 4 : 1)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
         );
      end
   endgenerate
   function automatic int lat(int k);
      return (k == 0) ? 4 : 1;
   endfunction
   task automatic chk(string tag, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d edge %0d: got %h expected %h", tag, k, e, act, exp);
      end
   endtask
   task automatic reset_model();
      for (int k = 0; k < 2; k++) begin
         g_e[k] = -100;
         free_e[k] = 0;
         last[k] = REQ_FETCH;
         who[k] = REQ_DATA;
         m_we[k] = 1'b0;
         m_byte[k] = 1'b0;
         m_addr[k] = '0;
         m_wdata[k] = '0;
         exp_d[k] = '0;
         exp_i[k] = '0;
      end
   endtask
   // a grant at edge G owns the port for cycles G..G+L-1, readies in cycle G+L, next grant at G+L+2
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (e == g_e[k] + lat(k) && !m_we[k]) begin
            if (who[k] == REQ_DATA) exp_d[k] = mem_rdata[k];
            else exp_i[k] = mem_rdata[k];
         end
         if (e >= free_e[k] && (d_req[k] || i_req[k])) begin
            who[k] = (d_req[k] && i_req[k]) ? ~last[k] : (i_req[k] ? REQ_FETCH : REQ_DATA);
            last[k] = who[k];
            m_addr[k] = (who[k] == REQ_FETCH) ? i_addr[k] : d_addr[k];
            m_wdata[k] = (who[k] == REQ_FETCH) ? 32'h0 : d_wdata[k];
            m_we[k] = (who[k] == REQ_DATA) && d_we[k];
            m_byte[k] = (who[k] == REQ_DATA) && d_is_byte[k];
            g_e[k] = e;
            free_e[k] = e + lat(k) + 2;
         end
      end
   endtask
   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         logic acc, dn;
         acc = (e >= g_e[k]) && (e <= g_e[k] + lat(k) - 1);
         dn = (e == g_e[k] + lat(k));
         chk("busy", k, 32'(busy[k]), 32'(acc || dn));
         chk("d_ready", k, 32'(d_ready[k]), 32'(dn && who[k] == REQ_DATA));
         chk("i_ready", k, 32'(i_ready[k]), 32'(dn && who[k] == REQ_FETCH));
         chk("mem_write_en", k, 32'(mem_write_en[k]), 32'(acc && e == g_e[k] && m_we[k]));
         chk("mem_is_byte", k, 32'(mem_is_byte[k]), 32'(acc && m_byte[k]));
         chk("mem_addr", k, mem_addr[k], acc ? m_addr[k] : 32'h0);
         chk("mem_wdata", k, mem_wdata[k], acc ? m_wdata[k] : 32'h0);
         chk("d_rdata", k, d_rdata[k], exp_d[k]);
         chk("i_rdata", k, i_rdata[k], exp_i[k]);
      end
   endtask
   task automatic check_zero();
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", k, 32'(busy[k]), 32'h0);
         chk("rst_d_ready", k, 32'(d_ready[k]), 32'h0);
         chk("rst_i_ready", k, 32'(i_ready[k]), 32'h0);
         chk("rst_mem_write_en", k, 32'(mem_write_en[k]), 32'h0);
         chk("rst_mem_is_byte", k, 32'(mem_is_byte[k]), 32'h0);
         chk("rst_mem_addr", k, mem_addr[k], 32'h0);
         chk("rst_mem_wdata", k, mem_wdata[k], 32'h0);
         chk("rst_d_rdata", k, d_rdata[k], 32'h0);
         chk("rst_i_rdata", k, i_rdata[k], 32'h0);
      end
   endtask
   // requesters hold req until their ready, then drop for at least one cycle; fields churn every cycle
   task automatic drive(int p);
      for (int k = 0; k < 2; k++) begin
         logic dn;
         dn = (e == g_e[k] + lat(k));
         if (dn && who[k] == REQ_DATA) d_req[k] = 1'b0;
         else if (!d_req[k] && $urandom_range(99) < p) d_req[k] = 1'b1;
         if (dn && who[k] == REQ_FETCH) i_req[k] = 1'b0;
         else if (!i_req[k] && $urandom_range(99) < p) i_req[k] = 1'b1;
         d_we[k] = 1'($urandom_range(1));
         d_is_byte[k] = 1'($urandom_range(1));
         d_addr[k] = $urandom;
         d_wdata[k] = $urandom;
         i_addr[k] = $urandom;
         mem_rdata[k] = $urandom;
      end
   endtask
   task automatic cycle(int p);
      @(posedge clk);
      e++;
      model_edge();
      @(negedge clk);
      check_outputs();
      drive(p);
   endtask
   initial begin
      int n;
      for (int k = 0; k < 2; k++) begin
         d_req[k] = 1'b0;
         i_req[k] = 1'b0;
         d_we[k] = 1'b0;
         d_is_byte[k] = 1'b0;
         d_addr[k] = '0;
         d_wdata[k] = '0;
         i_addr[k] = '0;
         mem_rdata[k] = '0;
      end
      reset_model();
      repeat (2) @(negedge clk);
      check_zero();
      rst_n = 1'b1;
      repeat (40) cycle(100);
      n = 0;
      while (!(e == g_e[0] + 2 && !m_we[0]) && n < 200) begin
         cycle(100);
         n++;
      end
      chk("reach_third_access", 0, 32'(n < 200), 32'h1);
      #2 rst_n = 1'b0;
      #1 check_zero();
      @(posedge clk);
      e++;
      @(negedge clk);
      check_zero();
      reset_model();
      for (int k = 0; k < 2; k++) begin
         d_req[k] = 1'b1;
         i_req[k] = 1'b1;
      end
      rst_n = 1'b1;
      repeat (30) cycle(100);
      repeat (1500) cycle(30);
      repeat (1000) cycle(80);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
